// File: rtl/mcdp_pkg.sv
// Shared constants and types for the multi-cycle LEGv8-subset datapath.
package mcdp_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_e;

    typedef enum logic [2:0] {CL_R, CL_LDUR, CL_STUR, CL_CBZ, CL_B, CL_ILL} iclass_e;

endpackage

// File: rtl/mcdp_decode.sv
// Combinational instruction decoder: class, ALU op, register selects, immediates.
module mcdp_decode
    import mcdp_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic [31:0]       ir_i,
    output alu_op_e           alu_op_o,
    output iclass_e           iclass_o,
    output logic [4:0]        rsel1_o,
    output logic [4:0]        rsel2_o,
    output logic [4:0]        wsel_o,
    output logic [DATA_W-1:0] imm_d_o,
    output logic [ADDR_W-1:0] imm_br_o,
    output logic              illegal_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        iclass_o = CL_ILL;
        case (ir_i[31:21])
            OP_ADD:  iclass_o = CL_R;
            OP_SUB:  begin iclass_o = CL_R; alu_op_o = ALU_SUB; end
            OP_AND:  begin iclass_o = CL_R; alu_op_o = ALU_AND; end
            OP_ORR:  begin iclass_o = CL_R; alu_op_o = ALU_ORR; end
            OP_LDUR: iclass_o = CL_LDUR;
            OP_STUR: iclass_o = CL_STUR;
            default: begin
                if (ir_i[31:24] == OP_CBZ)
                    iclass_o = CL_CBZ;
                else if (ir_i[31:26] == OP_B)
                    iclass_o = CL_B;
            end
        endcase
    end

    // Stores and CBZ read Rt on port 2 so the value is available in B.
    assign rsel1_o   = ir_i[9:5];
    assign rsel2_o   = (iclass_o == CL_STUR || iclass_o == CL_CBZ) ? ir_i[4:0] : ir_i[20:16];
    assign wsel_o    = ir_i[4:0];
    assign illegal_o = (iclass_o == CL_ILL);

    assign imm_d_o  = DATA_W'($signed(ir_i[20:12]));
    assign imm_br_o = (iclass_o == CL_CBZ) ? ADDR_W'($signed({ir_i[23:5], 2'b00}))
                                           : ADDR_W'($signed({ir_i[25:0], 2'b00}));

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle LEGv8-subset datapath: FETCH/DECODE/EXEC/MEM/WB FSM with
// req/ack memories, external register file, retire pulse and sticky trap.
module multicycle_datapath
    import mcdp_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [4:0]        rf_rsel1,
    output logic [4:0]        rf_rsel2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [4:0]        rf_wsel,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              retire,
    output logic              trap
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;

    alu_op_e           alu_op;
    iclass_e           cls;
    logic [DATA_W-1:0] imm_d, opb, alu_res;
    logic [ADDR_W-1:0] imm_br;
    logic              illegal;

    mcdp_decode #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dec (
        .ir_i      (ir_q),
        .alu_op_o  (alu_op),
        .iclass_o  (cls),
        .rsel1_o   (rf_rsel1),
        .rsel2_o   (rf_rsel2),
        .wsel_o    (rf_wsel),
        .imm_d_o   (imm_d),
        .imm_br_o  (imm_br),
        .illegal_o (illegal)
    );

    assign opb = (cls == CL_R) ? b_q : imm_d;

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = a_q - opb;
            ALU_AND: alu_res = a_q & opb;
            ALU_ORR: alu_res = a_q | opb;
            default: alu_res = a_q + opb;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        case (state_q)
            FETCH: begin
                // The reset state is FETCH, so the request is held off until rst is released.
                imem_req = rst;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rf_rdata1;
                b_d     = rf_rdata2;
                state_d = illegal ? TRAP : EXEC;
            end
            EXEC: begin
                alu_d = alu_res;
                case (cls)
                    CL_R:             state_d = WB;
                    CL_LDUR, CL_STUR: state_d = MEM;
                    CL_CBZ: begin
                        pc_d    = (b_q == '0) ? pc_q + imm_br : pc_q + ADDR_W'(4);
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    CL_B: begin
                        pc_d    = pc_q + imm_br;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default:          state_d = TRAP;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CL_STUR);
                if (dmem_ack) begin
                    if (cls == CL_STUR) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                pc_d    = pc_q + ADDR_W'(4);
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = TRAP;
        endcase
    end

    assign trap       = (state_q == TRAP);
    assign imem_addr  = pc_q;
    assign dmem_addr  = ADDR_W'(alu_q);
    assign dmem_wdata = b_q;
    assign rf_wdata   = (cls == CL_LDUR) ? mdr_q : alu_q;

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle LEGv8-subset datapath with its own FSM; successor to the single-cycle datapath.
- Instruction and data memories sit behind req/ack handshakes, so wait states are tolerated.
- The register file stays external and is driven through select, data and enable ports.
- Adds stall handling, retire and trap reporting, and a configurable data width and reset PC.

Parameters:
- DATA_W, 64, datapath, register and data-memory width.
- ADDR_W, 64, PC and memory address width.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (the PC).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  access complete; dmem_rdata valid on loads.
- dmem_rdata  in  DATA_W  load data.
- rf_rsel1  out  5  register file read select 1.
- rf_rsel2  out  5  register file read select 2.
- rf_rdata1  in  DATA_W  read data 1 (combinational).
- rf_rdata2  in  DATA_W  read data 2 (combinational).
- rf_wsel  out  5  write select.
- rf_wdata  out  DATA_W  write data.
- rf_we  out  1  write enable.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky; illegal opcode seen, core halted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, PC=PC_RESET, IR=0, trap=0.
  - All req/we/retire outputs 0; imem_addr=PC_RESET.
  - Any in-flight transaction is abandoned.
  - First fetch request in the first clock after rst rises.
- Handshake:
  - req is held high with address/data stable until a cycle with ack=1.
  - The transfer completes in that cycle and req drops the next cycle unless a new request follows.
  - ack with req=0 is ignored.
- Decoded subset: IR[31:21] for D/R types, IR[31:24] for CB, IR[31:26] for B.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100, B 000101.
- Register fields and immediates:
  - Fields: Rd/Rt=IR[4:0], Rn=IR[9:5], Rm=IR[20:16].
  - rf_rsel2=Rt for STUR/CBZ, otherwise Rm.
  - D-type: sext(IR[20:12]).
  - CB: sext(IR[23:5])<<2.
  - B: sext(IR[25:0])<<2.
  - All immediates are sign-extended to the target width.
- FSM states:
  - FETCH: imem_req=1; on ack latch IR <- imem_rdata, go to DECODE.
  - DECODE: drive the read selects; latch A <- rf_rdata1, B <- rf_rdata2.
    - Illegal opcode: go to TRAP.
    - Otherwise go to EXEC.
  - EXEC: ALU computes on A and (B or the D-immediate); result is latched into ALUOUT.
    - R-type: go to WB.
    - LDUR/STUR: go to MEM, address = A + imm.
    - CBZ: if B==0, PC <- PC+imm, else PC <- PC+4; retire=1; go to FETCH.
    - B: PC <- PC+imm; retire=1; go to FETCH.
  - MEM: dmem_req=1, dmem_we=(STUR), dmem_addr=ALUOUT, dmem_wdata=B.
    - On ack, LDUR: MDR <- dmem_rdata, go to WB.
    - On ack, STUR: PC <- PC+4, retire=1, go to FETCH.
  - WB: rf_we=1 for one cycle, rf_wsel=Rd, rf_wdata = MDR for LDUR else ALUOUT; PC <- PC+4; retire=1; go to FETCH.
  - TRAP: terminal; trap=1 and all req=0 until reset.
- Latency with ack tied high (cycles, fetch to retire inclusive):
  - R-type 4, LDUR 5, STUR 4, CBZ/B 3.
  - Each wait cycle adds one.
- Arithmetic:
  - Modulo 2^DATA_W; SUB is A-B two's complement.
  - PC arithmetic is modulo 2^ADDR_W, so wrap-around from max to 0 is legal.
- Register 31: writes to X31 are still issued; XZR semantics belong to the register file.
- rf_we is never asserted outside WB, including during TRAP or reset.

Decomposition:
- Package mcdp_pkg holds:
  - Opcode constants.
  - State enum (FETCH, DECODE, EXEC, MEM, WB, TRAP).
  - ALU-op enum (ADD, SUB, AND, ORR).
- Sub-module mcdp_decode (combinational): IR in; ALU-op, instruction class, read selects, write select, immediate and illegal flag out.
- ALU is kept inline.

Test Plan:
- Reset: rst=0 for 3 cycles with PC_RESET=0x100 -> imem_addr=0x100, all req/we=0; first imem_req the cycle after rst rises.
- ADD X3,X1,X2 with rf_rdata1=5, rf_rdata2=7, acks tied high -> rf_we in cycle 4 only, rf_wsel=3, rf_wdata=12, retire=1, next imem_addr=PC+4.
- LDUR X4,[X1,#-8] with X1=0x40 and dmem_ack delayed 3 cycles -> dmem_addr=0x38 held stable while req=1, dmem_we=0; rf_wdata=dmem_rdata; retire at cycle 8.
- CBZ X2,#-4 (imm19=-4) at PC=0x20 with X2=0 -> next fetch at 0x10; with X2=1 -> next fetch at 0x24; rf_we never asserted.
- IR=0xFFFFFFFF -> trap=1 after DECODE, imem_req stays 0 for 20 cycles; rst pulse clears trap and fetching resumes at PC_RESET.
- STUR with rst asserted mid-MEM while dmem_ack=0 -> dmem_req drops immediately (asynchronously); after release PC=PC_RESET, no retire, no rf_we.
